// File: rtl/irq_sequencer.sv
// Interrupt sequencer: IE/IF registers, IME with delayed EI, a five M-cycle
// dispatch FSM that drives the push/jump datapath, and HALT wake-up.
module irq_sequencer (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        MCYC_STB,
  input  logic        INSN_BOUNDARY,
  input  logic [7:0]  CPU_IRQ_TRIG,
  input  logic        IE_WR,
  input  logic        IF_WR,
  input  logic [7:0]  D_IN,
  input  logic        EI_EXEC,
  input  logic        DI_EXEC,
  input  logic        RETI_EXEC,
  input  logic        HALT,
  output logic [7:0]  IE,
  output logic [7:0]  IF,
  output logic        IME,
  output logic        DISPATCH,
  output logic [2:0]  SEQ_STEP,
  output logic        PUSH_HI,
  output logic        PUSH_LO,
  output logic [15:0] VEC_A,
  output logic [7:0]  CPU_IRQ_ACK,
  output logic        WAKE
);

  // Encodings double as the SEQ_STEP output code
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWait1  = 3'd1,
    StWait2  = 3'd2,
    StPushHi = 3'd3,
    StPushLo = 3'd4,
    StJump   = 3'd5
  } state_e;

  state_e      state_q, state_d;

  logic [7:0]  ie_q, ie_d;
  logic [7:0]  if_q, if_d;
  logic        ime_q, ime_d;
  // Instruction boundaries still to pass before a pending EI takes effect
  logic [1:0]  ei_cnt_q, ei_cnt_d;

  logic [2:0]  win_q, win_d;
  logic        win_vld_q, win_vld_d;
  logic [7:0]  ack_q, ack_d;
  logic [15:0] vec_q, vec_d;
  logic        wake_q;
  logic        dispatch_q;
  logic        push_hi_q;
  logic        push_lo_q;

  logic [7:0]  pending;
  logic        any_pending;
  logic [2:0]  pend_win;
  logic        bnd_stb;
  logic        dispatching;
  logic        start;
  logic        sample;
  logic        enter_jump;

  assign pending     = ie_q & if_q;
  assign any_pending = |pending;
  assign bnd_stb     = INSN_BOUNDARY & MCYC_STB;
  assign dispatching = (state_q != StIdle);
  assign start       = ~dispatching & bnd_stb & ime_q & any_pending;
  assign sample      = (state_q == StPushHi) & MCYC_STB;
  assign enter_jump  = (state_q == StPushLo) & MCYC_STB;

  // Priority encode pending requests, bit 0 highest
  always_comb begin
    pend_win = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pending[i]) begin
        pend_win = 3'(i);
      end
    end
  end

  // Dispatch state sequencing: only the IDLE exit depends on anything but MCYC_STB
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start)    state_d = StWait1;
      StWait1:  if (MCYC_STB) state_d = StWait2;
      StWait2:  if (MCYC_STB) state_d = StPushHi;
      StPushHi: if (MCYC_STB) state_d = StPushLo;
      StPushLo: if (MCYC_STB) state_d = StJump;
      StJump:   if (MCYC_STB) state_d = StIdle;
      default:                state_d = StIdle;
    endcase
  end

  // Winner latch, acknowledge pulse and jump vector for the next cycle
  always_comb begin
    win_d     = win_q;
    win_vld_d = win_vld_q;
    if (sample) begin
      win_d     = pend_win;
      win_vld_d = any_pending;
    end

    ack_d = 8'd0;
    if (enter_jump && win_vld_q) begin
      ack_d = 8'd1 << win_q;
    end

    // win_q cannot change while in JUMP, so the vector is stable for the whole state
    vec_d = 16'h0000;
    if ((state_d == StJump) && win_vld_q) begin
      vec_d = {9'd0, 1'b1, win_q, 3'b000};
    end
  end

  // IE/IF next state: write, then acknowledge clear, then new requests on top
  always_comb begin
    ie_d = IE_WR ? D_IN : ie_q;
    if_d = IF_WR ? D_IN : if_q;
    if_d = if_d & ~ack_d;
    if_d = if_d | CPU_IRQ_TRIG;
  end

  // IME next state; entering dispatch has the final say
  always_comb begin
    ime_d    = ime_q;
    ei_cnt_d = ei_cnt_q;

    if (bnd_stb && (ei_cnt_q != 2'd0)) begin
      ei_cnt_d = ei_cnt_q - 2'd1;
      if (ei_cnt_q == 2'd1) begin
        ime_d = 1'b1;
      end
    end

    if (!dispatching) begin
      // Boundaries are counted strictly after the EI cycle itself
      if (EI_EXEC) begin
        ei_cnt_d = 2'd2;
      end
      if (DI_EXEC) begin
        ime_d    = 1'b0;
        ei_cnt_d = 2'd0;
      end
      if (RETI_EXEC) begin
        ime_d = 1'b1;
      end
    end

    if (start) begin
      ime_d    = 1'b0;
      ei_cnt_d = 2'd0;
    end
  end

  // Interrupt enable/flag registers and master enable
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      ie_q     <= 8'd0;
      if_q     <= 8'd0;
      ime_q    <= 1'b0;
      ei_cnt_q <= 2'd0;
    end else begin
      ie_q     <= ie_d;
      if_q     <= if_d;
      ime_q    <= ime_d;
      ei_cnt_q <= ei_cnt_d;
    end
  end

  // Dispatch FSM with registered datapath controls
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= StIdle;
      win_q      <= 3'd0;
      win_vld_q  <= 1'b0;
      ack_q      <= 8'd0;
      vec_q      <= 16'h0000;
      dispatch_q <= 1'b0;
      push_hi_q  <= 1'b0;
      push_lo_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      win_vld_q  <= win_vld_d;
      ack_q      <= ack_d;
      vec_q      <= vec_d;
      dispatch_q <= (state_d != StIdle);
      push_hi_q  <= (state_d == StPushHi);
      push_lo_q  <= (state_d == StPushLo);
    end
  end

  // Wake from HALT on any enabled pending request, regardless of IME
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      wake_q <= 1'b0;
    end else begin
      wake_q <= HALT & any_pending;
    end
  end

  assign IE          = ie_q;
  assign IF          = if_q;
  assign IME         = ime_q;
  assign DISPATCH    = dispatch_q;
  assign SEQ_STEP    = state_q;
  assign PUSH_HI     = push_hi_q;
  assign PUSH_LO     = push_lo_q;
  assign VEC_A       = vec_q;
  assign CPU_IRQ_ACK = ack_q;
  assign WAKE        = wake_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Self-checking bench for irq_sequencer: vector table, directed corner cases
// and randomized traffic against a behavioural model.
module tb_irq_sequencer;

  logic        CLK = 1'b0;
  logic        nRESET;
  logic        MCYC_STB;
  logic        INSN_BOUNDARY;
  logic [7:0]  CPU_IRQ_TRIG;
  logic        IE_WR;
  logic        IF_WR;
  logic [7:0]  D_IN;
  logic        EI_EXEC;
  logic        DI_EXEC;
  logic        RETI_EXEC;
  logic        HALT;
  logic [7:0]  IE;
  logic [7:0]  IF;
  logic        IME;
  logic        DISPATCH;
  logic [2:0]  SEQ_STEP;
  logic        PUSH_HI;
  logic        PUSH_LO;
  logic [15:0] VEC_A;
  logic [7:0]  CPU_IRQ_ACK;
  logic        WAKE;

  irq_sequencer dut (
    .CLK           (CLK),
    .nRESET        (nRESET),
    .MCYC_STB      (MCYC_STB),
    .INSN_BOUNDARY (INSN_BOUNDARY),
    .CPU_IRQ_TRIG  (CPU_IRQ_TRIG),
    .IE_WR         (IE_WR),
    .IF_WR         (IF_WR),
    .D_IN          (D_IN),
    .EI_EXEC       (EI_EXEC),
    .DI_EXEC       (DI_EXEC),
    .RETI_EXEC     (RETI_EXEC),
    .HALT          (HALT),
    .IE            (IE),
    .IF            (IF),
    .IME           (IME),
    .DISPATCH      (DISPATCH),
    .SEQ_STEP      (SEQ_STEP),
    .PUSH_HI       (PUSH_HI),
    .PUSH_LO       (PUSH_LO),
    .VEC_A         (VEC_A),
    .CPU_IRQ_ACK   (CPU_IRQ_ACK),
    .WAKE          (WAKE)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [63:0] dut_bus();
    return {16'd0, IE, IF, IME, DISPATCH, SEQ_STEP, PUSH_HI, PUSH_LO, VEC_A, CPU_IRQ_ACK, WAKE};
  endfunction

  // ---------------- behavioural model ----------------
  logic [7:0] m_ie, m_if, m_ack;
  bit         m_ime, m_wake;
  int         m_ei_left;  // boundaries left until a pending EI enables
  int         m_phase;    // M-cycles into the dispatch, 0 = idle
  int         m_win;      // latched winner, -1 = none

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_ie = 0; m_if = 0; m_ack = 0; m_ime = 0; m_wake = 0;
    m_ei_left = 0; m_phase = 0; m_win = -1;
  endtask

  // Apply one rising edge using the inputs currently driven
  task automatic model_step();
    logic [7:0] p;
    bit         busy, bs, start;
    p     = m_ie & m_if;
    busy  = (m_phase != 0);
    bs    = INSN_BOUNDARY && MCYC_STB;
    start = !busy && bs && m_ime && (p != 0);
    m_ack  = 0;
    m_wake = HALT && (p != 0);
    if (busy && MCYC_STB) begin
      if (m_phase == 3) m_win = lowest(p);
      m_phase = (m_phase + 1) % 6;
      if (m_phase == 5 && m_win >= 0) m_ack = 8'(1 << m_win);
    end
    m_if = (IF_WR ? D_IN : m_if) & ~m_ack | CPU_IRQ_TRIG;
    if (IE_WR) m_ie = D_IN;
    if (bs && m_ei_left > 0) begin
      m_ei_left--;
      if (m_ei_left == 0) m_ime = 1;
    end
    if (!busy) begin
      if (EI_EXEC) m_ei_left = 2;
      if (DI_EXEC) begin m_ime = 0; m_ei_left = 0; end
      if (RETI_EXEC) m_ime = 1;
    end
    if (start) begin
      m_ime = 0; m_ei_left = 0; m_phase = 1;
    end
  endtask

  function automatic logic [63:0] model_bus();
    logic [15:0] vec;
    vec = (m_phase == 5 && m_win >= 0) ? 16'h0040 + 16'(8 * m_win) : 16'h0000;
    return {16'd0, m_ie, m_if, m_ime, m_phase != 0, 3'(m_phase), m_phase == 3, m_phase == 4,
            vec, m_ack, m_wake};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_inputs();
    MCYC_STB = 0; INSN_BOUNDARY = 0; CPU_IRQ_TRIG = 0; IE_WR = 0; IF_WR = 0; D_IN = 0;
    EI_EXEC = 0; DI_EXEC = 0; RETI_EXEC = 0; HALT = 0;
  endtask

  task automatic do_reset();
    clr_inputs();
    nRESET = 0;
    cyc();
    cyc();
    nRESET = 1;
    cyc();
  endtask

  task automatic wr_ie(input logic [7:0] v);
    IE_WR = 1; D_IN = v; cyc(); IE_WR = 0;
  endtask

  task automatic wr_if(input logic [7:0] v);
    IF_WR = 1; D_IN = v; cyc(); IF_WR = 0;
  endtask

  task automatic reti();
    RETI_EXEC = 1; cyc(); RETI_EXEC = 0;
  endtask

  // One M-cycle end strobe lasting one CLK; caller adds gap cycles
  task automatic strobe(input logic bnd);
    MCYC_STB = 1; INSN_BOUNDARY = bnd; cyc(); MCYC_STB = 0; INSN_BOUNDARY = 0;
  endtask

  task automatic run_dispatch(output logic [7:0] ack, output logic [15:0] vec,
                              output logic [7:0] ifv);
    strobe(1); cyc();
    for (int s = 2; s <= 4; s++) begin strobe(0); cyc(); end
    strobe(0);
    ack = CPU_IRQ_ACK; vec = VEC_A; ifv = IF;
    cyc();
    strobe(0); cyc();
  endtask

  typedef struct {
    logic [7:0]  ie;
    logic [7:0]  ifv;
    logic [7:0]  ack;
    logic [15:0] vec;
    logic [7:0]  if_after;
  } vec_t;

  vec_t        tbl[6];
  logic [7:0]  g_ack, g_if, acc;
  logic [15:0] g_vec;
  int          r;

  initial begin
    tbl[0] = '{8'h05, 8'h04, 8'h04, 16'h0050, 8'h00};
    tbl[1] = '{8'h1F, 8'h12, 8'h02, 16'h0048, 8'h10};
    tbl[2] = '{8'hFF, 8'hFF, 8'h01, 16'h0040, 8'hFE};
    tbl[3] = '{8'hF0, 8'hA0, 8'h20, 16'h0068, 8'h80};
    tbl[4] = '{8'h80, 8'hFF, 8'h80, 16'h0078, 8'h7F};
    tbl[5] = '{8'h0C, 8'h0E, 8'h04, 16'h0050, 8'h0A};

    clr_inputs();
    nRESET = 0;
    cyc();
    check("reset_state", dut_bus(), 64'd0);
    nRESET = 1;
    cyc();
    check("post_reset_idle", dut_bus(), 64'd0);

    // Basic dispatch walk-through, step by step
    do_reset();
    wr_ie(8'h05);
    reti();
    check("reti_ime", IME, 1);
    CPU_IRQ_TRIG = 8'h04; cyc(); CPU_IRQ_TRIG = 0;
    check("trig_if", IF, 8'h04);
    strobe(1);
    check("step1", {DISPATCH, SEQ_STEP, IME}, {1'b1, 3'd1, 1'b0});
    cyc(); strobe(0);
    check("step2", SEQ_STEP, 2);
    cyc(); strobe(0);
    check("step3", {SEQ_STEP, PUSH_HI, PUSH_LO}, {3'd3, 1'b1, 1'b0});
    cyc(); strobe(0);
    check("step4", {SEQ_STEP, PUSH_HI, PUSH_LO, CPU_IRQ_ACK}, {3'd4, 1'b0, 1'b1, 8'h00});
    cyc(); strobe(0);
    check("step5", {SEQ_STEP, CPU_IRQ_ACK, VEC_A, IF}, {3'd5, 8'h04, 16'h0050, 8'h00});
    cyc();
    check("ack_one_clk", {CPU_IRQ_ACK, VEC_A}, {8'h00, 16'h0050});
    strobe(0);
    check("back_idle", {DISPATCH, SEQ_STEP, VEC_A, IME}, {1'b0, 3'd0, 16'h0, 1'b0});

    // Priority / vector table
    foreach (tbl[k]) begin
      do_reset();
      wr_ie(tbl[k].ie);
      wr_if(tbl[k].ifv);
      reti();
      run_dispatch(g_ack, g_vec, g_if);
      check($sformatf("tbl%0d_ack", k), g_ack, tbl[k].ack);
      check($sformatf("tbl%0d_vec", k), g_vec, tbl[k].vec);
      check($sformatf("tbl%0d_if", k), g_if, tbl[k].if_after);
    end

    // IE cleared during PUSH_HI: dispatch completes with null vector
    do_reset();
    wr_ie(8'h01); wr_if(8'h01); reti();
    strobe(1); cyc(); strobe(0); cyc(); strobe(0); cyc();
    wr_ie(8'h00);
    strobe(0); cyc(); strobe(0);
    check("cancel_jump", {SEQ_STEP, CPU_IRQ_ACK, VEC_A, IF}, {3'd5, 8'h00, 16'h0, 8'h01});
    cyc(); strobe(0); cyc();

    // Trigger on the winner in the ack cycle is kept
    do_reset();
    wr_ie(8'h04); wr_if(8'h04); reti();
    strobe(1); cyc();
    for (int s = 2; s <= 4; s++) begin strobe(0); cyc(); end
    CPU_IRQ_TRIG = 8'h04;
    strobe(0);
    CPU_IRQ_TRIG = 0;
    check("retrig_keep", {CPU_IRQ_ACK, IF}, {8'h04, 8'h04});
    cyc(); strobe(0); cyc();

    // Trigger wins over a simultaneous IF write
    do_reset();
    IF_WR = 1; D_IN = 8'h01; CPU_IRQ_TRIG = 8'h08; cyc();
    IF_WR = 0; CPU_IRQ_TRIG = 0;
    check("trig_over_wr", IF, 8'h09);

    // EI takes effect only after the following instruction
    do_reset();
    wr_ie(8'h01); wr_if(8'h01);
    EI_EXEC = 1; cyc(); EI_EXEC = 0;
    strobe(1);
    check("ei_boundary", {DISPATCH, IME}, 2'b00);
    cyc(); strobe(1);
    check("nop_boundary", {DISPATCH, IME}, 2'b01);
    cyc(); strobe(1);
    check("ei_dispatch", {DISPATCH, SEQ_STEP}, {1'b1, 3'd1});
    cyc();
    for (int s = 2; s <= 6; s++) begin strobe(0); cyc(); end
    check("ei_done", {DISPATCH, IF}, {1'b0, 8'h00});

    // DI before the NOP boundary cancels the pending EI
    do_reset();
    wr_ie(8'h01); wr_if(8'h01);
    EI_EXEC = 1; cyc(); EI_EXEC = 0;
    strobe(1); cyc();
    DI_EXEC = 1; cyc(); DI_EXEC = 0;
    strobe(1);
    check("di_cancel_ime", IME, 0);
    cyc(); strobe(1);
    check("di_no_dispatch", DISPATCH, 0);

    // HALT wake-up without IME
    do_reset();
    wr_ie(8'h01);
    HALT = 1; CPU_IRQ_TRIG = 8'h01; cyc(); CPU_IRQ_TRIG = 0;
    check("wake_latency", WAKE, 0);
    cyc();
    check("wake_set", {WAKE, DISPATCH}, 2'b10);
    HALT = 0; cyc();
    check("wake_clear", WAKE, 0);

    // Reset asserted in PUSH_LO aborts the dispatch
    do_reset();
    wr_ie(8'h01); wr_if(8'h01); reti();
    strobe(1); cyc();
    for (int s = 2; s <= 4; s++) begin strobe(0); cyc(); end
    check("in_push_lo", PUSH_LO, 1);
    nRESET = 0;
    #1;
    check("async_reset", dut_bus(), 64'd0);
    cyc();
    nRESET = 1;
    acc = 0;
    for (int s = 0; s < 12; s++) begin
      MCYC_STB = s[0]; cyc(); acc |= CPU_IRQ_ACK;
    end
    MCYC_STB = 0;
    check("abort_no_ack", {acc, IF, DISPATCH}, {8'h00, 8'h00, 1'b0});

    // Randomized traffic against the model
    do_reset();
    model_reset();
    for (int n = 0; n < 4000; n++) begin
      MCYC_STB      = ($urandom_range(0, 2) == 0);
      INSN_BOUNDARY = $urandom_range(0, 1);
      CPU_IRQ_TRIG  = 8'($urandom) & 8'($urandom) & 8'($urandom) & 8'($urandom);
      IE_WR         = ($urandom_range(0, 15) == 0);
      IF_WR         = ($urandom_range(0, 15) == 0);
      D_IN          = 8'($urandom);
      HALT          = ($urandom_range(0, 3) == 0);
      r             = $urandom_range(0, 15);
      EI_EXEC       = (r == 0);
      DI_EXEC       = (r == 1);
      RETI_EXEC     = (r == 2 || r == 3);
      model_step();
      cyc();
      check($sformatf("rand%0d", n), dut_bus(), model_bus());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/irq_sequencer.md
IRQ_SEQUENCER -- requirements
Module: irq_sequencer

Interface
REQ-001 SHALL have port: CLK  in  1  single core clock; all state changes on rising edge.
REQ-002 SHALL have port: nRESET  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: MCYC_STB  in  1  one-CLK pulse marking the last CLK of each M-cycle.
REQ-004 SHALL have port: INSN_BOUNDARY  in  1  high while the current M-cycle precedes an opcode fetch.
REQ-005 SHALL have port: CPU_IRQ_TRIG  in  8  level interrupt requests; bit 0 is highest priority.
REQ-006 SHALL have ports: IE_WR, IF_WR  in  1 each, and D_IN  in  8  register write strobes and data.
REQ-007 SHALL have ports: EI_EXEC, DI_EXEC, RETI_EXEC, HALT  in  1 each  decoder and halt status.
REQ-008 SHALL have ports: IE, IF  out  8 each  register contents.
REQ-009 SHALL have ports: IME  out  1, and DISPATCH  out  1 (sequencer not IDLE).
REQ-010 SHALL have ports: SEQ_STEP  out  3, PUSH_HI  out  1, and PUSH_LO  out  1  datapath sequencing.
REQ-011 SHALL have ports: VEC_A  out  16, CPU_IRQ_ACK  out  8, and WAKE  out  1.

Function
REQ-012 SHALL define pending P = IE & IF and winner = lowest set index of P.
REQ-013 SHALL set IF[i] on every CLK where CPU_IRQ_TRIG[i]=1.
REQ-014 SHALL load IF from D_IN on IF_WR; a same-CLK TRIG set SHALL win over the write for that bit.
REQ-015 SHALL load IE from D_IN on IE_WR.
REQ-016 SHALL clear IME and any pending EI on DI_EXEC.
REQ-017 SHALL set IME at the second INSN_BOUNDARY&MCYC_STB after EI_EXEC, so IME becomes 1 after the instruction following EI.
REQ-018 SHALL set IME on the CLK after RETI_EXEC with no delay.
REQ-019 SHALL implement states with SEQ_STEP codes IDLE=0, WAIT1=1, WAIT2=2, PUSH_HI=3, PUSH_LO=4, JUMP=5.
REQ-020 SHALL advance from a non-IDLE state only on MCYC_STB, stepping 1->2->3->4->5->0, so dispatch takes 5 M-cycles.
REQ-021 SHALL leave IDLE for WAIT1 when INSN_BOUNDARY & MCYC_STB & IME & (P!=0).
REQ-022 SHALL clear IME and any pending EI on the CLK that leaves IDLE.
REQ-023 SHALL assert PUSH_HI only in state 3 and PUSH_LO only in state 4.
REQ-024 SHALL sample P and latch the winner on the MCYC_STB that ends PUSH_HI.
REQ-025 SHALL, when P=0 at that sample, drive VEC_A=0x0000 in JUMP and SHALL not pulse ACK.
REQ-026 SHALL otherwise drive VEC_A = 0x0040 + 8*winner in JUMP and 0x0000 in all other states.
REQ-027 SHALL pulse CPU_IRQ_ACK[winner] for exactly one CLK on the CLK entering JUMP, and SHALL clear IF[winner] on that CLK.
REQ-028 SHALL let a same-CLK TRIG on the winner bit re-set IF[winner] after the ACK clear, so the new request is kept.
REQ-029 SHALL register WAKE = HALT & (P!=0), independent of IME, with one CLK latency.
REQ-030 SHALL ignore EI_EXEC, DI_EXEC and RETI_EXEC while DISPATCH=1.
REQ-031 SHALL hold CPU_IRQ_ACK=0 in all CLKs other than the CLK entering JUMP.

Reset
REQ-032 SHALL, while nRESET=0, force IE=0, IF=0, IME=0, EI pending=0, state IDLE, SEQ_STEP=0, DISPATCH=0, PUSH_HI=0, PUSH_LO=0, VEC_A=0x0000, CPU_IRQ_ACK=0 and WAKE=0.
REQ-033 SHALL abort a dispatch in progress on reset assertion, with no ACK pulse and no IF change after release.
REQ-034 SHALL resume operation on the first CLK edge after nRESET deasserts; released state = IDLE with IME=0.

Verification
REQ-035 Setup IE=0x05, IME=1, TRIG pulse bit2 -> dispatch on the next INSN_BOUNDARY; SEQ_STEP 1..5; ACK=0x04 for one CLK; VEC_A=0x0050; IF=0x00; IME=0.
REQ-036 With IE=0x1F and IF set to 0x12, run a dispatch -> winner bit1, VEC_A=0x0048, IF=0x10.
REQ-037 During PUSH_HI, IE_WR writes 0x00 -> VEC_A=0x0000, no ACK, IF unchanged.
REQ-038 Sequence EI, NOP with P!=0 -> no dispatch at the EI boundary; dispatch starts after the NOP; a DI before the NOP boundary prevents the dispatch.
REQ-039 With IME=0, HALT=1, IE=0x01, TRIG bit0 -> WAKE=1 one CLK later, DISPATCH stays 0.
REQ-040 Pull nRESET low in PUSH_LO -> all outputs 0 immediately; after release there is no ACK and IF=0x00.
